// File: rtl/fp32_pkg.sv
// fp32_pkg: constants and encodings shared by the fp32 multiplier and divider
package fp32_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    // One accept cycle, one unpack cycle, QBITS divide cycles, one round cycle
    localparam int LATENCY = 29;
    localparam int QBITS   = LATENCY - 3;

    typedef enum logic [1:0] {IDLE, UNPACK, DIV, ROUND} div_state_e;

    typedef enum logic [1:0] {CLS_ZERO, CLS_NORMAL, CLS_INF, CLS_NAN} fp_class_e;

endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack: classify one IEEE-754 single and split it into sign, exponent and 24-bit significand
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0] x,
    output logic        sign,
    output logic [7:0]  expo,
    output logic [23:0] man,
    output logic [1:0]  cls
);

    // Denormals have no hidden bit and are classed as zero
    always_comb begin
        sign = x[31];
        expo = x[30:23];
        man  = {expo != 8'd0, x[22:0]};
        cls  = (expo == 8'd0) ? CLS_ZERO :
               (expo != 8'(EXP_MAX)) ? CLS_NORMAL :
               (x[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end

endmodule

// File: rtl/fp32_iter_divider.sv
// fp32_iter_divider: fixed-latency radix-2 restoring fp32 divider, Q = A / B, round-to-nearest-even
module fp32_iter_divider
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Q,
    output logic        invalid,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow
);

    div_state_e state, state_nx;
    logic [31:0] a_r, b_r;
    logic sa, sb;
    logic [7:0] ea, eb;
    logic [23:0] ma, mb;
    logic [1:0] ca, cb;
    logic signed [9:0] exp_r, exp_fin;
    logic [24:0] rem_r, sum;
    logic [25:0] q_r;
    logic [4:0] cnt_r;
    logic ge, sign, norm, rnd, sticky, up;
    logic [23:0] rem_sub, sig;
    logic [22:0] frac;
    logic is_inv, is_inf, is_dbz, is_zero, is_ovf, is_unf;
    logic [31:0] q_nx;

    fp32_unpack u_a (.x(a_r), .sign(sa), .expo(ea), .man(ma), .cls(ca));
    fp32_unpack u_b (.x(b_r), .sign(sb), .expo(eb), .man(mb), .cls(cb));

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (start ? UNPACK : IDLE) :
                   (state == UNPACK) ? DIV :
                   (state == DIV) ? ((cnt_r == 5'(QBITS - 1)) ? ROUND : DIV) : IDLE;
    end

    assign busy = (state != IDLE);

    always_comb begin
        ge      = rem_r >= {1'b0, mb};
        rem_sub = ge ? 24'(rem_r - {1'b0, mb}) : rem_r[23:0];
        sign    = sa ^ sb;
        // Quotient lies in (1/2, 2); a clear integer bit costs one exponent step
        norm    = q_r[25];
        sig     = norm ? q_r[25:2] : q_r[24:1];
        rnd     = norm ? q_r[1] : q_r[0];
        sticky  = (norm & q_r[0]) | (rem_r != 25'd0);
        up      = rnd & (sticky | sig[0]);
        sum     = {1'b0, sig} + 25'(up);
        frac    = sum[24] ? sum[23:1] : sum[22:0];
        exp_fin = exp_r - 10'(!norm) + 10'(sum[24]);
        is_inv  = ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_ZERO && cb == CLS_ZERO) ||
                  (ca == CLS_INF && cb == CLS_INF);
        is_inf  = !is_inv && (ca == CLS_INF || cb == CLS_ZERO);
        is_dbz  = is_inf && ca == CLS_NORMAL;
        is_zero = !is_inv && !is_inf && (ca == CLS_ZERO || cb == CLS_INF);
        is_ovf  = !(is_inv || is_inf || is_zero) && exp_fin >= $signed(10'(EXP_MAX));
        is_unf  = !(is_inv || is_inf || is_zero) && exp_fin <= 10'sd0;
        q_nx    = is_inv ? QNAN :
                  (is_inf || is_ovf) ? (POS_INF | {sign, 31'd0}) :
                  (is_zero || is_unf) ? {sign, 31'd0} : {sign, exp_fin[7:0], frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            exp_r       <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            cnt_r       <= '0;
            done        <= 1'b0;
            Q           <= '0;
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            done <= (state == ROUND);
            if (state == IDLE && start) begin
                a_r <= A;
                b_r <= B;
            end
            if (state == UNPACK) begin
                exp_r <= {2'b00, ea} - {2'b00, eb} + 10'(EXP_BIAS);
                rem_r <= {1'b0, ma};
                q_r   <= '0;
                cnt_r <= '0;
            end
            if (state == DIV) begin
                rem_r <= {rem_sub, 1'b0};
                q_r   <= {q_r[24:0], ge};
                cnt_r <= cnt_r + 5'd1;
            end
            if (state == ROUND) begin
                Q           <= q_nx;
                invalid     <= is_inv;
                div_by_zero <= is_dbz;
                overflow    <= is_ovf;
                underflow   <= is_unf;
            end
        end
    end

endmodule

// File: tb/tb_fp32_iter_divider.sv
// tb_fp32_iter_divider: directed vectors with literal expectations plus an arithmetic reference model
module tb_fp32_iter_divider;

    localparam int LATENCY = 29;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic busy, done, invalid, div_by_zero, overflow, underflow;
    logic [31:0] Q;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          due;
        logic [31:0] q;
        logic [3:0]  fl;
    } exp_t;

    exp_t pend[$];
    logic [31:0] hold_q = '0;
    logic [3:0]  hold_fl = '0;
    int ncyc = 0;

    fp32_iter_divider dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Q(Q), .invalid(invalid),
        .div_by_zero(div_by_zero), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Exact quotient via one wide integer division, then RNE on the leading 24 bits
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        longint unsigned ma, mb, n, r, sig, rest, half;
        bit an, ai, az, bn, bi, bz, up;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        an = (ea == 255) && (a[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bz = (eb == 0);
        bn = (eb == 255) && (b[22:0] != 0);
        bi = (eb == 255) && (b[22:0] == 0);
        if (an || bn || (az && bz) || (ai && bi)) return {4'b1000, 32'h7FC00000};
        if (ai) return {4'b0000, s, 8'hFF, 23'd0};
        if (bz) return {4'b0100, s, 8'hFF, 23'd0};
        if (az || bi) return {4'b0000, s, 31'd0};
        ma = 64'(a[22:0]) | 64'h800000;
        mb = 64'(b[22:0]) | 64'h800000;
        n  = (ma << 40) / mb;
        r  = (ma << 40) % mb;
        e  = ea - eb + 127;
        if (n < (64'd1 << 40)) begin
            e  = e - 1;
            sh = 16;
        end else begin
            sh = 17;
        end
        sig  = n >> sh;
        rest = n & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        up   = (rest > half) || (rest == half && (r != 0 || sig[0]));
        sig  = sig + 64'(up);
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0001, s, 31'd0};
        return {4'b0000, s, 8'(e), 23'(sig)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Compare process: every cycle, outputs against the model's expected handshake and held result
    always @(negedge clk) begin
        logic cur_done, cur_busy;
        logic [35:0] r;
        ncyc++;
        cur_done = pend.size() > 0 && pend[0].due == ncyc;
        cur_busy = pend.size() > 0 && ncyc < pend[0].due;
        if (cur_done) begin
            hold_q  = pend[0].q;
            hold_fl = pend[0].fl;
        end
        check("busy", 32'(busy), 32'(cur_busy));
        check("done", 32'(done), 32'(cur_done));
        check("q_model", Q, hold_q);
        check("flags_model", 32'({invalid, div_by_zero, overflow, underflow}), 32'(hold_fl));
        if (cur_done) void'(pend.pop_front());
        if (rst) begin
            pend.delete();
            hold_q  = '0;
            hold_fl = '0;
        end else if (start && !cur_busy) begin
            r = model(A, B);
            pend.push_back('{due: ncyc + LATENCY, q: r[31:0], fl: r[35:32]});
        end
    end

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want_q,
                       input logic [3:0] want_fl, input bit lit);
        int k;
        @(posedge clk);
        #1 A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; A = $urandom(); B = $urandom();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 45);
        check("latency", k, LATENCY);
        if (lit) begin
            check("q_lit", Q, want_q);
            check("flags_lit", 32'({invalid, div_by_zero, overflow, underflow}), 32'(want_fl));
        end
    endtask

    task automatic hold_start();
        int first, second, cnt;
        first = 0; second = 0; cnt = 0;
        @(posedge clk);
        #1 A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                if (cnt == 1) begin
                    first = c;
                    check("hs_q1", Q, 32'h40400000);
                end else begin
                    second = c;
                    check("hs_q2", Q, 32'h3EAAAAAB);
                end
            end
            @(posedge clk);
            #1;
            if (c == 5) begin
                A = 32'h3F800000;
                B = 32'h40400000;
            end
            if (c == 40) start = 1'b0;
        end
        check("hs_dones", cnt, 2);
        check("hs_first", first, LATENCY);
        check("hs_second", second, 2 * LATENCY);
    endtask

    task automatic reset_mid_op();
        int cnt;
        cnt = 0;
        @(posedge clk);
        #1 A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", Q, 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("rst_no_done", cnt, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_q", Q, 32'd0);
        check("reset_flags", 32'({invalid, div_by_zero, overflow, underflow}), 32'd0);

        run(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
        run(32'h3FC00000, 32'h3FC00000, 32'h3F800000, 4'b0000, 1'b1);
        run(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b1);
        run(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 1'b1);
        run(32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 4'b0010, 1'b1);
        run(32'h00800000, 32'h7F7FFFFF, 32'h00000000, 4'b0001, 1'b1);
        run(32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b0010, 1'b1);
        run(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000, 1'b1);
        run(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 1'b1);
        run(32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 1'b1);
        run(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1'b1);
        run(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1'b1);
        run(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1'b1);
        run(32'h7F800000, 32'hBF800000, 32'hFF800000, 4'b0000, 1'b1);
        run(32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 1'b1);
        run(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1'b1);
        run(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1'b1);
        run(32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1'b1);
        run(32'hBF800000, 32'h00400000, 32'hFF800000, 4'b0100, 1'b1);
        run(32'h40490FDB, 32'h402DF854, 32'h0, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++)
            run({1'($urandom_range(0, 1)), 8'($urandom_range(60, 190)), 23'($urandom())},
                {1'($urandom_range(0, 1)), 8'($urandom_range(60, 190)), 23'($urandom())},
                32'h0, 4'b0000, 1'b0);

        hold_start();
        reset_mid_op();
        run(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b1);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
